// File: rtl/quad_step_gen.sv
// rtl/quad_step_gen.sv - quadrature step generator (optional position accumulator: QUAD_STEP_GEN_POS_EN)
module quad_step_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [DIV_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    sensor1_data,
    output logic                    sensor2_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    state_t           state, state_nx;
    logic [1:0]       ph, ph_nx;
    logic             dir, dir_nx;
    logic [CNT_W-1:0] steps_left, steps_nx;
    logic [DIV_W-1:0] timer, timer_nx;
    logic [DIV_W-1:0] per_m1, per_m1_nx;
    logic             done_nx;
    logic [DIV_W-1:0] cmd_per_m1;

    // Phase index to {sensor2, sensor1} Gray pattern.
    function automatic logic [1:0] gray(input logic [1:0] p);
        case (p)
            2'd0:    gray = 2'b00;
            2'd1:    gray = 2'b01;
            2'd2:    gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == RUN);
    assign cmd_per_m1 = (cmd_period == '0) ? '0 : cmd_period - DIV_ONE;

    // Next-state logic: accept commands in IDLE, pace and emit transitions in RUN.
    always_comb begin
        state_nx  = state;
        ph_nx     = ph;
        dir_nx    = dir;
        steps_nx  = steps_left;
        timer_nx  = timer;
        per_m1_nx = per_m1;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps != '0) begin
                        dir_nx    = cmd_dir;
                        steps_nx  = cmd_steps;
                        timer_nx  = cmd_per_m1;
                        per_m1_nx = cmd_per_m1;
                        state_nx  = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (timer != '0) begin
                    timer_nx = timer - DIV_ONE;
                end else begin
                    ph_nx    = dir ? ph + 2'd1 : ph - 2'd1;
                    steps_nx = steps_left - CNT_ONE;
                    timer_nx = per_m1;
                    if (steps_left == CNT_ONE) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; sensors are registered from the next phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ph           <= 2'd0;
            dir          <= 1'b0;
            steps_left   <= '0;
            timer        <= '0;
            per_m1       <= '0;
            done         <= 1'b0;
            sensor1_data <= 1'b0;
            sensor2_data <= 1'b0;
        end else begin
            state        <= state_nx;
            ph           <= ph_nx;
            dir          <= dir_nx;
            steps_left   <= steps_nx;
            timer        <= timer_nx;
            per_m1       <= per_m1_nx;
            done         <= done_nx;
            {sensor2_data, sensor1_data} <= gray(ph_nx);
        end
    end

`ifdef QUAD_STEP_GEN_POS_EN
    localparam logic [POS_W-1:0] POS_ONE = 1;
    logic [POS_W-1:0] pos_q;

    // Every phase change is exactly one step in the latched direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else if (ph_nx != ph) begin
            pos_q <= dir ? pos_q + POS_ONE : pos_q - POS_ONE;
        end
    end

    assign position = pos_q;
`else
    assign position = '0;
`endif

endmodule

// File: tb/tb_quad_step_gen.sv
// tb/tb_quad_step_gen.sv - directed self-checking bench for quad_step_gen
module tb_quad_step_gen;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [15:0]       cmd_steps;
    logic [15:0]       cmd_period;
    logic              abort;
    logic              sensor1_data;
    logic              sensor2_data;
    logic              busy;
    logic              done;
    logic signed [23:0] position;

    int checks = 0;
    int failures = 0;

    quad_step_gen dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_steps    (cmd_steps),
        .cmd_period   (cmd_period),
        .abort        (abort),
        .sensor1_data (sensor1_data),
        .sensor2_data (sensor2_data),
        .busy         (busy),
        .done         (done),
        .position     (position)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input int p);
        logic [23:0] v;
`ifdef QUAD_STEP_GEN_POS_EN
        v = p[23:0];
`else
        v = 24'd0 + (p & 0);
`endif
        return {8'h0, v};
    endfunction

    function automatic logic [31:0] sens();
        return {30'd0, sensor2_data, sensor1_data};
    endfunction

    function automatic logic [31:0] pos();
        return {8'h0, position};
    endfunction

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = 16'd0;
        cmd_period = 16'd0;
        abort      = 1'b0;
        step();
        step();
        chk("rst_sens", sens(), 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pos", pos(), pexp(0));
        reset = 1'b0;
        step();

        // CW: 5 steps, period 3
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd3;
        step();
        cmd_valid = 1'b0;
        chk("cw_busy", {31'd0, busy}, 32'd1);
        chk("cw_ready", {31'd0, cmd_ready}, 32'd0);
        chk("cw_sens0", sens(), 32'd0);
        step(); step();
        chk("cw_hold", sens(), 32'd0);
        step();
        chk("cw_t1", sens(), 32'b01);
        step(); step(); step();
        chk("cw_t2", sens(), 32'b11);
        step(); step(); step();
        chk("cw_t3", sens(), 32'b10);
        step(); step(); step();
        chk("cw_t4", sens(), 32'b00);
        chk("cw_nodone", {31'd0, done}, 32'd0);
        step(); step(); step();
        chk("cw_t5", sens(), 32'b01);
        chk("cw_done", {31'd0, done}, 32'd1);
        chk("cw_idle", {31'd0, busy}, 32'd0);
        chk("cw_pos", pos(), pexp(5));
        step();
        chk("cw_done_once", {31'd0, done}, 32'd0);

        // ACW: 4 steps, period 1, from 01
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd4; cmd_period = 16'd1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("acw_t1", sens(), 32'b00);
        step();
        chk("acw_t2", sens(), 32'b10);
        step();
        chk("acw_t3", sens(), 32'b11);
        step();
        chk("acw_t4", sens(), 32'b01);
        chk("acw_done", {31'd0, done}, 32'd1);
        chk("acw_pos", pos(), pexp(1));
        step();

        // zero steps
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd0; cmd_period = 16'd7;
        step();
        cmd_valid = 1'b0;
        chk("zs_done", {31'd0, done}, 32'd1);
        chk("zs_busy", {31'd0, busy}, 32'd0);
        chk("zs_sens", sens(), 32'b01);
        step();
        chk("zs_done_once", {31'd0, done}, 32'd0);

        // period 0 behaves as period 1
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 16'd0;
        step();
        cmd_valid = 1'b0;
        step();
        chk("p0_t1", sens(), 32'b11);
        step();
        chk("p0_t2", sens(), 32'b10);
        chk("p0_done", {31'd0, done}, 32'd1);
        chk("p0_pos", pos(), pexp(3));
        step();

        // abort at N+9 with period 4: two transitions only
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd4;
        step();
        cmd_valid = 1'b0;
        step(); step(); step(); step();
        chk("ab_t1", sens(), 32'b00);
        step(); step(); step(); step();
        chk("ab_t2", sens(), 32'b01);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_ready", {31'd0, cmd_ready}, 32'd1);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_nodone", {31'd0, done}, 32'd0);
        step(); step(); step(); step();
        chk("ab_hold", sens(), 32'b01);
        chk("ab_nodone2", {31'd0, done}, 32'd0);
        chk("ab_pos", pos(), pexp(5));

        // back-to-back with cmd_valid held; cmd changes during RUN ignored
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 16'd1;
        step();
        cmd_dir = 1'b0; cmd_steps = 16'd1; cmd_period = 16'd2;
        step();
        chk("bb_t1", sens(), 32'b11);
        step();
        chk("bb_t2", sens(), 32'b10);
        chk("bb_done", {31'd0, done}, 32'd1);
        chk("bb_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("bb_accept2", {31'd0, busy}, 32'd1);
        chk("bb_done_clr", {31'd0, done}, 32'd0);
        step();
        chk("bb_wait", sens(), 32'b10);
        step();
        chk("bb2_t1", sens(), 32'b11);
        chk("bb2_done", {31'd0, done}, 32'd1);
        chk("bb_pos", pos(), pexp(6));
        step();

        // async reset mid-RUN
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd4; cmd_period = 16'd1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("ar_pre", sens(), 32'b10);
        #2 reset = 1'b1;
        #1;
        chk("ar_sens", sens(), 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_ready", {31'd0, cmd_ready}, 32'd1);
        chk("ar_pos", pos(), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("ar_stay", sens(), 32'd0);
        chk("ar_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
